tetris_move_ctrl: RTL and testbench



---
 rtl/tetris_move_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_tetris_move_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_move_ctrl.sv
// Falling-piece position/rotation holder: turns key levels into clamped moves, with optional delayed auto-shift.
// Latency: 1 cycle from a sampled key edge (or repeat tick) to updated pos/rot and the moved/landed pulse.
// Backpressure: none; each cycle resolves at most one action by priority load > left > right > down > ro.
// Build option: define TETRIS_MOVE_AUTOREPEAT_EN to include the auto-repeat FSM; otherwise keys act on rise only.
module tetris_move_ctrl #(
  parameter int X_W       = 5,
  parameter int Y_W       = 5,
  parameter int ROT_W     = 2,
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 20,
  parameter int NUM_ROT   = 4,
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [ROT_W-1:0] rot_in,
  input  logic             left,
  input  logic             right,
  input  logic             down,
  input  logic             ro,
  output logic [X_W-1:0]   pos_x,
  output logic [Y_W-1:0]   pos_y,
  output logic [ROT_W-1:0] rot,
  output logic             moved,
  output logic             landed
);

  // Direction codes double as priority rank (lower value wins) and key_now index.
  localparam logic [1:0] K_LEFT  = 2'd0;
  localparam logic [1:0] K_RIGHT = 2'd1;
  localparam logic [1:0] K_DOWN  = 2'd2;

  logic [3:0]       key_now;   // {ro, down, right, left}
  logic [3:0]       key_q, key_d;
  logic [3:0]       rise;
  logic             conflict;
  logic             rise_any;
  logic [1:0]       rise_sel;
  logic             dir_go;
  logic [1:0]       dir_key;

  logic [X_W-1:0]   pos_x_q, pos_x_d;
  logic [Y_W-1:0]   pos_y_q, pos_y_d;
  logic [ROT_W-1:0] rot_q, rot_d;
  logic             moved_q, moved_d;
  logic             landed_q, landed_d;

  assign key_now  = {ro, down, right, left};
  assign rise     = key_now & ~key_q;
  assign conflict = left & right;

  // Pick the highest-priority direction key that was freshly pressed this cycle.
  always_comb begin
    rise_any = 1'b1;
    rise_sel = K_LEFT;
    if (rise[0])      rise_sel = K_LEFT;
    else if (rise[1]) rise_sel = K_RIGHT;
    else if (rise[2]) rise_sel = K_DOWN;
    else              rise_any = 1'b0;
  end

`ifdef TETRIS_MOVE_AUTOREPEAT_EN
  localparam int CNT_W = $clog2(DAS_DELAY + DAS_RATE + 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_held;
  logic             cnt_hit;
  logic             restart;

  assign act_held = key_now[act_q];
  assign cnt_hit  = (state_q == S_DELAY) ? (cnt_q == CNT_W'(DAS_DELAY - 1))
                                         : (cnt_q == CNT_W'(DAS_RATE - 1));
  // Re-arm from scratch when idle, when the tracked key was let go, or when a
  // more urgent direction has just been pressed on top of it.
  assign restart  = (state_q == S_IDLE) || !act_held ||
                    (rise_any && (rise_sel < act_q));

  // Auto-repeat state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      act_q   <= K_LEFT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
    end
  end

  // Auto-repeat next-state: track one held direction and count toward the next tick.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    if (load || conflict) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (restart) begin
      cnt_d   = '0;
      state_d = S_IDLE;
      if (rise_any) begin
        state_d = S_DELAY;
        act_d   = rise_sel;
      end
    end else if (cnt_hit) begin
      state_d = S_REPEAT;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Auto-repeat output: which direction (if any) acts this cycle.
  always_comb begin
    dir_go  = 1'b0;
    dir_key = K_LEFT;
    if (load) begin
      dir_go = 1'b0;
    end else if (conflict) begin
      dir_go  = rise[2];
      dir_key = K_DOWN;
    end else if (restart) begin
      dir_go  = rise_any;
      dir_key = rise_sel;
    end else if (cnt_hit) begin
      dir_go  = 1'b1;
      dir_key = act_q;
    end
  end
`else
  // Without auto-repeat a direction only acts on its press edge.
  always_comb begin
    dir_go  = 1'b0;
    dir_key = K_LEFT;
    if (!load) begin
      if (conflict) begin
        dir_go  = rise[2];
        dir_key = K_DOWN;
      end else begin
        dir_go  = rise_any;
        dir_key = rise_sel;
      end
    end
  end
`endif

  // Datapath: apply the winning action with board clamping and rotation wrap.
  always_comb begin
    key_d    = key_now;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    rot_d    = rot_q;
    moved_d  = 1'b0;
    landed_d = 1'b0;
    if (load) begin
      pos_x_d = x_in;
      pos_y_d = y_in;
      rot_d   = rot_in;
    end else if (dir_go) begin
      case (dir_key)
        K_LEFT: begin
          if (pos_x_q != '0) begin
            pos_x_d = pos_x_q - X_W'(1);
            moved_d = 1'b1;
          end
        end
        K_RIGHT: begin
          if (pos_x_q < X_W'(BOARD_W - 1)) begin
            pos_x_d = pos_x_q + X_W'(1);
            moved_d = 1'b1;
          end
        end
        default: begin
          if (pos_y_q < Y_W'(BOARD_H - 1)) begin
            pos_y_d = pos_y_q + Y_W'(1);
            moved_d = 1'b1;
          end else begin
            landed_d = 1'b1;
          end
        end
      endcase
    end else if (rise[3]) begin
      rot_d   = (rot_q == ROT_W'(NUM_ROT - 1)) ? '0 : rot_q + ROT_W'(1);
      moved_d = 1'b1;
    end
  end

  // Position, rotation, pulses and key history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q    <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      rot_q    <= '0;
      moved_q  <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      key_q    <= key_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      rot_q    <= rot_d;
      moved_q  <= moved_d;
      landed_q <= landed_d;
    end
  end

  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;
  assign rot    = rot_q;
  assign moved  = moved_q;
  assign landed = landed_q;

endmodule

// File: tb/tb_tetris_move_ctrl.sv
// Bench for tetris_move_ctrl: directed scenarios then random key streams against a behavioural model.
// Each step drives inputs, advances one clock, and compares all outputs #1 after the edge.
// Model tracks the held key and elapsed hold time directly rather than a state encoding.
module tb_tetris_move_ctrl;

  localparam int X_W       = 5;
  localparam int Y_W       = 5;
  localparam int ROT_W     = 2;
  localparam int BOARD_W   = 10;
  localparam int BOARD_H   = 20;
  localparam int NUM_ROT   = 4;
  localparam int DAS_DELAY = 16;
  localparam int DAS_RATE  = 4;

`ifdef TETRIS_MOVE_AUTOREPEAT_EN
  localparam int EXP_HOLD_MOVES = 7;
  localparam int EXP_HOLD_X     = 7;
  localparam int EXP_PRE_RST_X  = 6;
`else
  localparam int EXP_HOLD_MOVES = 1;
  localparam int EXP_HOLD_X     = 1;
  localparam int EXP_PRE_RST_X  = 4;
`endif

  logic             clk = 1'b0;
  logic             reset, load;
  logic [X_W-1:0]   x_in;
  logic [Y_W-1:0]   y_in;
  logic [ROT_W-1:0] rot_in;
  logic             left, right, down, ro;
  logic [X_W-1:0]   pos_x;
  logic [Y_W-1:0]   pos_y;
  logic [ROT_W-1:0] rot;
  logic             moved, landed;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int mx, my, mr;
  bit pl, pr, pd, po;
  int hold;
  int since;
  bit first;
  bit e_moved, e_landed;

  always #5 clk = ~clk;

  tetris_move_ctrl #(
    .X_W(X_W), .Y_W(Y_W), .ROT_W(ROT_W), .BOARD_W(BOARD_W), .BOARD_H(BOARD_H),
    .NUM_ROT(NUM_ROT), .DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .x_in(x_in), .y_in(y_in), .rot_in(rot_in),
    .left(left), .right(right), .down(down), .ro(ro),
    .pos_x(pos_x), .pos_y(pos_y), .rot(rot), .moved(moved), .landed(landed)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: one call per clock edge, given the inputs sampled there.
  task automatic model(input bit rst, input bit ld, input int xi, input int yi, input int ri,
                       input bit l, input bit r, input bit d, input bit o);
    bit lv[3];
    bit rs[3];
    int go;
    int fresh;
    int nx, ny, nr;
    lv[0] = l; lv[1] = r; lv[2] = d;
    rs[0] = l && !pl; rs[1] = r && !pr; rs[2] = d && !pd;
    e_moved = 0;
    e_landed = 0;
    go = -1;
    fresh = -1;
    if (rst) begin
      mx = 0; my = 0; mr = 0;
      pl = 0; pr = 0; pd = 0; po = 0;
      hold = -1; since = 0; first = 0;
      return;
    end
    nx = mx; ny = my; nr = mr;
    if (ld) begin
      nx = xi; ny = yi; nr = ri;
      hold = -1;
    end else begin
      if (l && r) begin
        hold = -1;
        if (rs[2]) go = 2;
      end else begin
        for (int k = 2; k >= 0; k--) if (rs[k]) fresh = k;
`ifdef TETRIS_MOVE_AUTOREPEAT_EN
        if (hold >= 0 && lv[hold] && !(fresh >= 0 && fresh < hold)) begin
          since++;
          if (since == (first ? DAS_DELAY : DAS_RATE)) begin
            go = hold;
            since = 0;
            first = 0;
          end
        end else begin
          hold = -1;
          if (fresh >= 0) begin
            go = fresh; hold = fresh; since = 0; first = 1;
          end
        end
`else
        go = fresh;
`endif
      end
      case (go)
        0: if (nx > 0) nx--;
        1: if (nx < BOARD_W - 1) nx++;
        2: if (ny < BOARD_H - 1) ny++; else e_landed = 1;
        default: if (o && !po) nr = (nr == NUM_ROT - 1) ? 0 : nr + 1;
      endcase
      e_moved = (nx != mx) || (ny != my) || (nr != mr);
    end
    mx = nx; my = ny; mr = nr;
    pl = l; pr = r; pd = d; po = o;
  endtask

  task automatic step(input bit rst, input bit ld, input int xi, input int yi, input int ri,
                      input bit l, input bit r, input bit d, input bit o);
    reset  = rst;
    load   = ld;
    x_in   = X_W'(xi);
    y_in   = Y_W'(yi);
    rot_in = ROT_W'(ri);
    left   = l; right = r; down = d; ro = o;
    model(rst, ld, xi, yi, ri, l, r, d, o);
    @(posedge clk);
    #1;
    chk("pos_x", pos_x, mx);
    chk("pos_y", pos_y, my);
    chk("rot", rot, mr);
    chk("moved", moved, e_moved);
    chk("landed", landed, e_landed);
  endtask

  initial begin
    int nmoves;
    bit kl, kr, kd, ko, rs, ld;
    reset = 1; load = 0; x_in = '0; y_in = '0; rot_in = '0;
    left = 0; right = 0; down = 0; ro = 0;
    mx = 0; my = 0; mr = 0; pl = 0; pr = 0; pd = 0; po = 0;
    hold = -1; since = 0; first = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_x", pos_x, 0);
    chk("reset_moved", moved, 0);

    // Rotation wrap 3 -> 0
    step(0, 1, 4, 0, 3, 0, 0, 0, 0);
    chk("load_no_moved", moved, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ro_wrap", rot, 0);
    chk("ro_moved", moved, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ro_pulse_end", moved, 0);

    // Left clamp at x=0, then right
    step(0, 1, 0, 5, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("left_clamp_x", pos_x, 0);
    chk("left_clamp_moved", moved, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("right_x", pos_x, 1);
    chk("right_moved", moved, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Down at bottom row lands
    step(0, 1, 3, 19, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("land_y", pos_y, 19);
    chk("land_pulse", landed, 1);
    chk("land_moved", moved, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("land_pulse_end", landed, 0);

    // Hold right 40 cycles from x=0
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    nmoves = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      if (moved) nmoves++;
    end
    chk("hold_moves", nmoves, EXP_HOLD_MOVES);
    chk("hold_final_x", pos_x, EXP_HOLD_X);

    // Load while repeating: spawn values take over and holding no longer moves
    step(0, 1, 2, 3, 1, 0, 1, 0, 0);
    chk("load_rep_x", pos_x, 2);
    nmoves = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      if (moved) nmoves++;
    end
    chk("load_idle_moves", nmoves, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Left+right conflict at x=5
    step(0, 1, 5, 4, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("conflict_x", pos_x, 5);
    chk("conflict_moved", moved, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a repeat
    step(0, 1, 3, 7, 2, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("pre_reset_x", pos_x, EXP_PRE_RST_X);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("mid_reset_x", pos_x, 0);
    chk("mid_reset_y", pos_y, 0);
    chk("mid_reset_rot", rot, 0);

    // Random key streams
    kl = 0; kr = 0; kd = 0; ko = 0;
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) kl = !kl;
      if ($urandom_range(0, 29) == 0) kr = !kr;
      if ($urandom_range(0, 29) == 0) kd = !kd;
      if ($urandom_range(0, 3) == 0)  ko = !ko;
      step(rs, ld, int'($urandom_range(0, BOARD_W - 1)), int'($urandom_range(0, BOARD_H - 1)),
           int'($urandom_range(0, NUM_ROT - 1)), kl, kr, kd, ko);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
